// File: rtl/fft_controller_if.sv
// Control/status/address bundle between the FFT sequencer and the butterfly datapath.
interface fft_controller_if #(
    parameter int N_LOG2 = 4
) ();
    logic                        start;
    logic                        busy;
    logic                        done;
    logic                        rd_en;
    logic                        wr_en;
    logic [N_LOG2-1:0]           addr_a;
    logic [N_LOG2-1:0]           addr_b;
    logic [N_LOG2-2:0]           twiddle_index;
    logic [$clog2(N_LOG2)-1:0]   stage;
    logic                        scale;

    modport master (
        input  start,
        output busy, done, rd_en, wr_en, addr_a, addr_b, twiddle_index, stage, scale
    );

    modport slave (
        output start,
        input  busy, done, rd_en, wr_en, addr_a, addr_b, twiddle_index, stage, scale
    );
endinterface

// File: rtl/fft_controller.sv
// In-place radix-2 FFT sequencer: one READ/WRITE pair per butterfly, N/2 butterflies per stage.
// Optional FFT_CTRL_STAGE_SCALE_EN: assert scale on every WRITE (per-stage divide-by-2).
module fft_controller #(
    parameter int N_LOG2 = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    fft_controller_if.master bus
);
    localparam int AW = N_LOG2;
    localparam int TW = N_LOG2 - 1;
    localparam int SW = $clog2(N_LOG2);
    localparam int KW = N_LOG2 - 1;
    localparam logic [KW-1:0] K_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [TW-1:0] tw;
    } bfly_t;

    // addr_a clears bit s of k and shifts the group bits up; addr_b sets bit s.
    function automatic bfly_t bfly_addr(input logic [SW-1:0] s, input logic [KW-1:0] k);
        bfly_t         r;
        logic [AW-1:0] kk;
        logic [AW-1:0] span;
        logic [AW-1:0] pos;
        kk   = {1'b0, k};
        span = AW'(1) << s;
        pos  = kk & (span - 1'b1);
        r.a  = ((kk & ~(span - 1'b1)) << 1) | pos;
        r.b  = r.a | span;
        r.tw = TW'(pos << (S_LAST - s));
        return r;
    endfunction

    state_t        state;
    logic [SW-1:0] s;
    logic [KW-1:0] k;
    logic          busy_q;
    logic          done_q;
    logic          rd_q;
    logic          wr_q;
    bfly_t         ad;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            s      <= '0;
            k      <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            ad     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= READ;
                        s      <= '0;
                        k      <= '0;
                        busy_q <= 1'b1;
                        rd_q   <= 1'b1;
                        ad     <= bfly_addr('0, '0);
                    end
                end
                READ: begin
                    // Addresses held: the write-back targets the pair just read.
                    state <= WRITE;
                    rd_q  <= 1'b0;
                    wr_q  <= 1'b1;
                end
                WRITE: begin
                    wr_q <= 1'b0;
                    if (k != K_LAST) begin
                        state <= READ;
                        k     <= k + 1'b1;
                        rd_q  <= 1'b1;
                        ad    <= bfly_addr(s, k + 1'b1);
                    end else if (s != S_LAST) begin
                        state <= READ;
                        k     <= '0;
                        s     <= s + 1'b1;
                        rd_q  <= 1'b1;
                        ad    <= bfly_addr(s + 1'b1, '0);
                    end else begin
                        state  <= DONE;
                        k      <= '0;
                        s      <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        ad     <= '0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.rd_en         = rd_q;
    assign bus.wr_en         = wr_q;
    assign bus.addr_a        = ad.a;
    assign bus.addr_b        = ad.b;
    assign bus.twiddle_index = ad.tw;
    assign bus.stage         = s;

`ifdef FFT_CTRL_STAGE_SCALE_EN
    assign bus.scale = wr_q;
`else
    assign bus.scale = 1'b0;
`endif

endmodule

// File: tb/tb_fft_controller.sv
// Self-checking bench for fft_controller: cycle-exact trace against a loop-based reference model.
module tb_fft_controller;
    localparam int N_LOG2 = 4;
    localparam int N      = 1 << N_LOG2;
    localparam int NB     = N / 2;
    localparam int AW     = N_LOG2;
    localparam int TW     = N_LOG2 - 1;
    localparam int SW     = $clog2(N_LOG2);
`ifdef FFT_CTRL_STAGE_SCALE_EN
    localparam bit SCALE_EN = 1'b1;
`else
    localparam bit SCALE_EN = 1'b0;
`endif

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          rd;
        logic          wr;
        logic          scale;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [TW-1:0] tw;
        logic [SW-1:0] stage;
    } obs_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    fft_controller_if #(.N_LOG2(N_LOG2)) bus ();
    fft_controller #(.N_LOG2(N_LOG2)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    obs_t exp_q[$];
    int total = 0;
    int bad   = 0;

    function automatic obs_t sample();
        obs_t o;
        o.busy  = bus.busy;
        o.done  = bus.done;
        o.rd    = bus.rd_en;
        o.wr    = bus.wr_en;
        o.scale = bus.scale;
        o.a     = bus.addr_a;
        o.b     = bus.addr_b;
        o.tw    = bus.twiddle_index;
        o.stage = bus.stage;
        return o;
    endfunction

    // Expected per-cycle outputs, starting with the cycle after start is sampled.
    function automatic void build_trace();
        obs_t o;
        exp_q.delete();
        for (int st = 0; st < N_LOG2; st++) begin
            for (int kb = 0; kb < NB; kb++) begin
                int span, pos, grp, a;
                span = 1 << st;
                pos  = kb % span;
                grp  = kb / span;
                a    = grp * 2 * span + pos;
                o       = '0;
                o.busy  = 1'b1;
                o.rd    = 1'b1;
                o.a     = AW'(a);
                o.b     = AW'(a + span);
                o.tw    = TW'(pos * (1 << (N_LOG2 - 1 - st)));
                o.stage = SW'(st);
                exp_q.push_back(o);
                o.rd    = 1'b0;
                o.wr    = 1'b1;
                o.scale = SCALE_EN;
                exp_q.push_back(o);
            end
        end
        o      = '0;
        o.done = 1'b1;
        exp_q.push_back(o);
        exp_q.push_back('0);
    endfunction

    // Caller raises start just after a rising edge; start is dropped after 'hold' edges.
    task automatic check_transform(input string name, input int hold);
        obs_t got;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
            if (i + 1 == hold) bus.start = 1'b0;
            @(negedge clk);
            got = sample();
            total++;
            if (got !== exp_q[i]) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", name, i + 1, got, exp_q[i]);
            end
        end
    endtask

    task automatic check_idle(input string name, input int cycles);
        obs_t got;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            got = sample();
            total++;
            if (got !== obs_t'('0)) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%h exp=0", name, i, got);
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b1;
        n_rst     = 1'b0;
        check_idle("reset_hold", 3);
        bus.start = 1'b0;
        n_rst     = 1'b1;
        check_idle("post_reset_idle", 2 + $urandom_range(0, 3));
    endtask

    task automatic test_single();
        @(posedge clk);
        #1 bus.start = 1'b1;
        check_transform("single_pulse", 1);
    endtask

    // Fixed reference points plus pulse accounting over a whole transform.
    task automatic test_addr_points();
        obs_t got;
        int   n_rd, n_wr, n_done, n_both, n_busy, done_cyc;
        logic prev_rd;
        n_rd = 0; n_wr = 0; n_done = 0; n_both = 0; n_busy = 0; done_cyc = 0;
        prev_rd = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b1;
        for (int c = 1; c <= 66; c++) begin
            @(posedge clk);
            #1 bus.start = 1'b0;
            @(negedge clk);
            got = sample();
            if (got.rd) n_rd++;
            if (got.wr) n_wr++;
            if (got.rd && got.wr) n_both++;
            if (got.wr && !prev_rd) n_both++;
            if (got.busy) n_busy++;
            if (got.done) begin n_done++; done_cyc = c; end
            prev_rd = got.rd;
            if (c == 7) begin
                total++;
                if ({got.rd, got.stage, got.a, got.b, got.tw} !== {1'b1, 2'd0, 4'd6, 4'd7, 3'd0}) begin
                    bad++;
                    $display("FAIL pt_s0k3 got=%h exp=%h", {got.rd, got.stage, got.a, got.b, got.tw},
                             {1'b1, 2'd0, 4'd6, 4'd7, 3'd0});
                end
            end
            if (c == 39) begin
                total++;
                if ({got.rd, got.stage, got.a, got.b, got.tw} !== {1'b1, 2'd2, 4'd3, 4'd7, 3'd6}) begin
                    bad++;
                    $display("FAIL pt_s2k3 got=%h exp=%h", {got.rd, got.stage, got.a, got.b, got.tw},
                             {1'b1, 2'd2, 4'd3, 4'd7, 3'd6});
                end
            end
            if (c == 60) begin
                total++;
                if ({got.wr, got.stage, got.a, got.b, got.tw} !== {1'b1, 2'd3, 4'd5, 4'd13, 3'd5}) begin
                    bad++;
                    $display("FAIL pt_s3k5 got=%h exp=%h", {got.wr, got.stage, got.a, got.b, got.tw},
                             {1'b1, 2'd3, 4'd5, 4'd13, 3'd5});
                end
            end
        end
        total++;
        if (n_rd != 32 || n_wr != 32 || n_both != 0) begin
            bad++;
            $display("FAIL strobes rd=%0d wr=%0d overlap=%0d exp 32/32/0", n_rd, n_wr, n_both);
        end
        total++;
        if (n_busy != 64 || n_done != 1 || done_cyc != 65) begin
            bad++;
            $display("FAIL timing busy=%0d done=%0d at %0d exp 64/1 at 65", n_busy, n_done, done_cyc);
        end
    endtask

    // Start held for a random span covering busy and DONE must not restart or queue.
    task automatic test_start_ignored();
        for (int r = 0; r < 3; r++) begin
            check_idle("gap", $urandom_range(1, 4));
            @(posedge clk);
            #1 bus.start = 1'b1;
            check_transform("start_ignored", $urandom_range(2, 66));
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk);
        #1 bus.start = 1'b1;
        check_transform("held_first", 67);
        check_transform("held_second", 1);
        check_idle("after_held", 2);
    endtask

    task automatic test_abort();
        obs_t got;
        int   stop;
        stop = $urandom_range(32, 47);
        @(posedge clk);
        #1 bus.start = 1'b1;
        for (int i = 0; i <= stop; i++) begin
            @(posedge clk);
            #1 bus.start = 1'b0;
            @(negedge clk);
            got = sample();
            total++;
            if (got !== exp_q[i]) begin
                bad++;
                $display("FAIL abort_pre cyc=%0d got=%h exp=%h", i + 1, got, exp_q[i]);
            end
        end
        #2 n_rst = 1'b0;
        #1;
        got = sample();
        total++;
        if (got !== obs_t'('0)) begin
            bad++;
            $display("FAIL abort_async got=%h exp=0", got);
        end
        check_idle("abort_hold", 2);
        n_rst = 1'b1;
        check_idle("abort_no_done", 4);
        @(posedge clk);
        #1 bus.start = 1'b1;
        check_transform("abort_restart", 1);
    endtask

    initial begin
        bus.start = 1'b0;
        build_trace();
        test_reset();
        test_single();
        test_addr_points();
        test_start_ignored();
        test_back_to_back();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
